// File: rtl/transmisor_multicarril_pkg.sv
// rtl/transmisor_multicarril_pkg.sv - symbol codes and FSM states for the multi-lane transmit front end
package transmisor_multicarril_pkg;

    localparam logic [7:0] K_COM      = 8'hBC;
    localparam logic [7:0] K_SKP      = 8'h1C;
    localparam logic [7:0] LOGIC_IDLE = 8'h00;

    typedef enum logic [1:0] {
        S_ELEC = 2'd0,
        S_DATA = 2'd1,
        S_COM  = 2'd2,
        S_SKP  = 2'd3
    } estado_t;

endpackage

// File: rtl/transmisor_multicarril_fifo.sv
// rtl/transmisor_multicarril_fifo.sv - first-word-fall-through synchronous FIFO with global enable
module fifo_sincrono #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // a full FIFO refuses a push even if the same cycle pops
    assign do_push = enb && push && (count < CW'(DEPTH));
    assign do_pop  = enb && pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (!do_push && do_pop)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/transmisor_multicarril.sv
// rtl/transmisor_multicarril.sv - multi-lane PCIe transmit front end: FIFO, lane striping, SKP insertion, electrical idle
module transmisor_multicarril
    import transmisor_multicarril_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int DEPTH        = 8,
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_LEN      = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enb,
    input  logic [8*LANES-1:0]         dataIn,
    input  logic [LANES-1:0]           kIn,
    input  logic                       validIn,
    output logic                       readyOut,
    input  logic                       elecIdleReq,
    output logic [8*LANES-1:0]         symOut,
    output logic [LANES-1:0]           kOut,
    output logic                       TxElecIdle,
    output logic                       skpActive,
    output logic [$clog2(DEPTH+1)-1:0] fifoCount
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(SKP_INTERVAL);

    estado_t            state;
    estado_t            state_nx;
    logic [IW-1:0]      int_cnt;
    logic [1:0]         skp_cnt;
    logic               skp_due;
    logic               skp_last;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [9*LANES-1:0] fifo_dout;
    logic [8*LANES-1:0] sym_d;
    logic [LANES-1:0]   k_d;
    logic               elec_d;
    logic               skp_d;

    assign readyOut   = enb && (fifoCount < CW'(DEPTH));
    assign push       = validIn && readyOut;
    assign fifo_empty = (fifoCount == '0);
    assign skp_due    = (int_cnt == IW'(SKP_INTERVAL-1));
    assign skp_last   = (skp_cnt == 2'(SKP_LEN-1));

    // each entry carries the K flags above the data bytes
    fifo_sincrono #(
        .WIDTH (9*LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .enb   (enb),
        .push  (push),
        .pop   (pop),
        .din   ({kIn, dataIn}),
        .dout  (fifo_dout),
        .count (fifoCount)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_ELEC;
        else if (enb)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_ELEC: if (!elecIdleReq) state_nx = S_COM;
            S_DATA: begin
                if (skp_due)
                    state_nx = S_COM;
                else if (elecIdleReq && fifo_empty)
                    state_nx = S_ELEC;
            end
            S_COM:  state_nx = S_SKP;
            S_SKP:  if (skp_last) state_nx = S_DATA;
            default: state_nx = S_ELEC;
        endcase
    end

    // symbol chosen for this state, captured by the output register
    always_comb begin
        pop    = 1'b0;
        sym_d  = {LANES{LOGIC_IDLE}};
        k_d    = '0;
        elec_d = 1'b0;
        skp_d  = 1'b0;
        case (state)
            S_ELEC: elec_d = 1'b1;
            S_DATA: begin
                if (!skp_due && !fifo_empty) begin
                    pop   = enb;
                    sym_d = fifo_dout[8*LANES-1:0];
                    k_d   = fifo_dout[9*LANES-1:8*LANES];
                end
            end
            S_COM: begin
                sym_d = {LANES{K_COM}};
                k_d   = '1;
                skp_d = 1'b1;
            end
            S_SKP: begin
                sym_d = {LANES{K_SKP}};
                k_d   = '1;
                skp_d = 1'b1;
            end
            default: elec_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            symOut     <= '0;
            kOut       <= '0;
            TxElecIdle <= 1'b1;
            skpActive  <= 1'b0;
        end else if (enb) begin
            symOut     <= sym_d;
            kOut       <= k_d;
            TxElecIdle <= elec_d;
            skpActive  <= skp_d;
        end
    end

    // interval counter saturates so a pending SKP request stays raised until served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_cnt <= '0;
            skp_cnt <= '0;
        end else if (enb) begin
            case (state)
                S_ELEC: int_cnt <= '0;
                S_DATA: if (!skp_due) int_cnt <= int_cnt + IW'(1);
                S_COM:  skp_cnt <= '0;
                S_SKP: begin
                    skp_cnt <= skp_cnt + 2'd1;
                    if (skp_last) int_cnt <= '0;
                end
                default: int_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_transmisor_multicarril.sv
// tb/tb_transmisor_multicarril.sv - bench for transmisor_multicarril
module tb_transmisor_multicarril;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [31:0] dataIn;
    logic [3:0]  kIn;
    logic        validIn;
    logic        readyOut;
    logic        elecIdleReq;
    logic [31:0] symOut;
    logic [3:0]  kOut;
    logic        TxElecIdle;
    logic        skpActive;
    logic [3:0]  fifoCount;

    int total = 0;
    int bad = 0;
    logic [35:0] q[$];
    int run = 0;
    int gap = 0;
    bit gap_valid = 1'b0;
    int delivered = 0;
    int coms = 0;
    int n;
    int d0;
    logic [35:0] w9;

    always #5 clk = ~clk;

    transmisor_multicarril #(
        .LANES        (4),
        .DEPTH        (8),
        .SKP_INTERVAL (16),
        .SKP_LEN      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enb         (enb),
        .dataIn      (dataIn),
        .kIn         (kIn),
        .validIn     (validIn),
        .readyOut    (readyOut),
        .elecIdleReq (elecIdleReq),
        .symOut      (symOut),
        .kOut        (kOut),
        .TxElecIdle  (TxElecIdle),
        .skpActive   (skpActive),
        .fifoCount   (fifoCount)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stream-level model: words leave in push order, ordered sets are COM + 3 SKP,
    // and exactly 16 enabled symbols separate one set from the next COM
    task automatic monitor(input bit en);
        logic [35:0] w;
        if (!en) begin
            chk("frozen_count", fifoCount, q.size());
            return;
        end
        if (TxElecIdle) begin
            chk("elec_sym", {kOut, symOut}, 36'h0);
            chk("elec_skp", skpActive, 1'b0);
            run = 0;
            gap_valid = 1'b0;
        end else if (skpActive) begin
            if (run == 0) begin
                chk("com_sym", {kOut, symOut}, 36'hF_BCBCBCBC);
                if (gap_valid) chk("skp_gap", gap, 16);
                gap_valid = 1'b0;
                coms++;
            end else begin
                chk("skp_sym", {kOut, symOut}, 36'hF_1C1C1C1C);
            end
            run++;
            if (run > 4) chk("skp_len_over", run, 4);
        end else begin
            if (run != 0) begin
                chk("skp_len", run, 4);
                run = 0;
                gap_valid = 1'b1;
                gap = 0;
            end
            if (gap_valid) begin
                gap++;
                if (gap == 17) chk("skp_overdue", gap, 16);
            end
            if ({kOut, symOut} != 36'h0) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", {kOut, symOut}, 36'h0);
                end else begin
                    w = q.pop_front();
                    chk("data_word", {kOut, symOut}, w);
                    delivered++;
                end
            end
        end
        chk("fifo_count", fifoCount, q.size());
    endtask

    task automatic step();
        logic [35:0] w;
        bit pushed;
        bit en;
        #1;
        chk("ready", readyOut, (enb && q.size() < 8));
        pushed = validIn && readyOut;
        w = {kIn, dataIn};
        en = enb;
        @(posedge clk);
        @(negedge clk);
        if (pushed) q.push_back(w);
        monitor(en);
    endtask

    initial begin
        rst = 1'b1;
        enb = 1'b1;
        validIn = 1'b0;
        elecIdleReq = 1'b1;
        dataIn = '0;
        kIn = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_sym", symOut, 32'h0);
        chk("rst_k", kOut, 4'h0);
        chk("rst_elec", TxElecIdle, 1'b1);
        chk("rst_skp", skpActive, 1'b0);
        chk("rst_count", fifoCount, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        chk("elec_hold", TxElecIdle, 1'b1);

        // exit electrical idle: COM then three SKP on every lane, then logical idle
        elecIdleReq = 1'b0;
        n = 0;
        while (!skpActive && n < 5) begin
            step();
            n++;
        end
        chk("t2_com", {TxElecIdle, skpActive, kOut, symOut}, {2'b01, 36'hF_BCBCBCBC});
        repeat (3) begin
            step();
            chk("t2_skp", {TxElecIdle, skpActive, kOut, symOut}, {2'b01, 36'hF_1C1C1C1C});
        end
        step();
        chk("t2_idle", {TxElecIdle, skpActive, kOut, symOut}, 38'h0);

        // latency and striping of a single word, then a freeze holds it
        validIn = 1'b1;
        dataIn = 32'h44332211;
        kIn = 4'h0;
        step();
        validIn = 1'b0;
        chk("t3_not_yet", symOut, 32'h0);
        step();
        chk("t3_word", {kOut, symOut}, 36'h0_44332211);
        chk("t3_lane0", symOut[7:0], 8'h11);
        enb = 1'b0;
        repeat (3) begin
            step();
            chk("t3_freeze", symOut, 32'h44332211);
        end
        enb = 1'b1;

        // backpressure: fill while parked in electrical idle
        elecIdleReq = 1'b1;
        n = 0;
        while (!TxElecIdle && n < 30) begin
            step();
            n++;
        end
        chk("t4_in_elec", TxElecIdle, 1'b1);
        for (int i = 0; i < 9; i++) begin
            validIn = 1'b1;
            dataIn = $urandom | 32'h1;
            kIn = 4'($urandom);
            chk("t4_ready", readyOut, (i < 8));
            step();
        end
        chk("t4_full", fifoCount, 4'd8);
        w9 = {kIn, dataIn};
        elecIdleReq = 1'b0;
        n = 0;
        while (!readyOut && n < 40) begin
            step();
            n++;
        end
        chk("t4_accept", readyOut, 1'b1);
        step();
        validIn = 1'b0;
        chk("t4_w9_queued", q[q.size()-1], w9);

        // randomized traffic with occasional enable drops
        for (int i = 0; i < 300; i++) begin
            enb = ($urandom_range(0, 9) != 0);
            validIn = ($urandom_range(0, 3) != 0);
            dataIn = $urandom | 32'h1;
            kIn = 4'($urandom);
            step();
        end
        enb = 1'b1;

        // asynchronous reset in the middle of the stream
        #2 rst = 1'b0;
        #1;
        chk("t1_sym", symOut, 32'h0);
        chk("t1_k", kOut, 4'h0);
        chk("t1_elec", TxElecIdle, 1'b1);
        chk("t1_skp", skpActive, 1'b0);
        chk("t1_count", fifoCount, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        run = 0;
        gap_valid = 1'b0;
        validIn = 1'b0;

        // continuous traffic: SKP sets keep their spacing, nothing is lost
        coms = 0;
        for (int i = 0; i < 100; i++) begin
            validIn = 1'b1;
            dataIn = $urandom | 32'h1;
            kIn = 4'($urandom);
            step();
        end
        validIn = 1'b0;
        chk("t5_skp_seen", (coms >= 4), 1'b1);
        n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("t5_drain", q.size(), 0);

        // idle entry with three words queued, then a frozen idle line
        d0 = delivered;
        for (int i = 0; i < 3; i++) begin
            validIn = 1'b1;
            dataIn = $urandom | 32'h1;
            kIn = 4'($urandom);
            if (i == 2) elecIdleReq = 1'b1;
            step();
        end
        validIn = 1'b0;
        n = 0;
        while (!TxElecIdle && n < 60) begin
            step();
            n++;
        end
        chk("t6_elec", TxElecIdle, 1'b1);
        chk("t6_words", delivered - d0, 3);
        enb = 1'b0;
        repeat (5) begin
            step();
            chk("t6_freeze", {TxElecIdle, kOut, symOut}, {1'b1, 36'h0});
        end
        enb = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
